// File: rtl/square_drawer.sv
// square_drawer: turns one square request (top-left, colour, fill/erase)
// into SIZE x SIZE single-pixel writes for the VGA adapter, one per clock,
// with a ready/start/done handshake toward the square selector.
//
// All outputs are registers. The pixel for the next cycle is computed from
// the next counter values, so the first pixel is on the outputs in the
// cycle right after start is accepted.
module square_drawer #(
  parameter int SIZE     = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  input  logic       in_fill,
  output logic       ready,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot
);

  // Offset counter width; SIZE is limited to 2..8 so this is 1..3 bits.
  localparam int CW = $clog2(SIZE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [8:0]    XLIM = 9'(SCREEN_W);
  localparam logic [7:0]    YLIM = 8'(SCREEN_H);

  logic [1:0]    state;
  logic [7:0]    x_l;
  logic [6:0]    y_l;
  logic [2:0]    colour_l;
  logic [CW-1:0] dx;
  logic [CW-1:0] dy;

  logic [CW-1:0] nxt_dx;
  logic [CW-1:0] nxt_dy;
  logic          last_px;
  logic [8:0]    sum_x;
  logic [7:0]    sum_y;
  logic [8:0]    start_x;
  logic [7:0]    start_y;
  logic [2:0]    start_colour;

  // A pixel is written only when its full-width coordinates land on screen;
  // the wider sums keep a square that runs past x=255 or y=127 from
  // wrapping back onto the visible area.
  function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
    return (sx < XLIM) && (sy < YLIM);
  endfunction

  // Row-major advance of the offset counters and the coordinates they address.
  always_comb begin
    nxt_dx  = dx;
    nxt_dy  = dy;
    last_px = (dx == LAST) && (dy == LAST);
    if (dx == LAST) begin
      nxt_dx = '0;
      nxt_dy = dy + ONE;
    end else begin
      nxt_dx = dx + ONE;
    end
    sum_x        = {1'b0, x_l} + 9'(nxt_dx);
    sum_y        = {1'b0, y_l} + 8'(nxt_dy);
    start_x      = {1'b0, in_x};
    start_y      = {1'b0, in_y};
    start_colour = in_fill ? in_colour : 3'b000;
  end

  // Control FSM, request latches and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      x_l        <= '0;
      y_l        <= '0;
      colour_l   <= '0;
      dx         <= '0;
      dy         <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          if (start) begin
            state      <= S_DRAW;
            x_l        <= in_x;
            y_l        <= in_y;
            colour_l   <= start_colour;
            dx         <= '0;
            dy         <= '0;
            ready      <= 1'b0;
            vga_x      <= in_x;
            vga_y      <= in_y;
            vga_colour <= start_colour;
            plot       <= on_screen(start_x, start_y);
          end
        end
        S_DRAW: begin
          ready <= 1'b0;
          if (last_px) begin
            // Last pixel was on the outputs this cycle; hold coordinates.
            state <= S_DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dx         <= nxt_dx;
            dy         <= nxt_dy;
            vga_x      <= sum_x[7:0];
            vga_y      <= sum_y[6:0];
            vga_colour <= colour_l;
            plot       <= on_screen(sum_x, sum_y);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          plot  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          plot  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_drawer.sv
// Testbench for square_drawer: table of square requests, expected pixel
// stream built from a reference model into a scoreboard queue, plus
// hand-written reset sequences.
module tb_square_drawer;

  localparam int SIZE = 4;
  localparam int SW   = 160;
  localparam int SH   = 120;
  localparam int NPIX = SIZE * SIZE;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_fill;
  logic       ready;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;

  square_drawer #(.SIZE(SIZE), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_x(in_x), .in_y(in_y),
    .in_colour(in_colour), .in_fill(in_fill), .ready(ready), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       fill;
    logic       poke;   // pulse a stray start mid-square
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
    logic       plot;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic check_idle(input string nm, input logic [7:0] ex, input logic [6:0] ey,
                            input logic [2:0] ec);
    chk({nm, " ready"}, 32'(ready), 32'd1);
    chk({nm, " plot"},  32'(plot),  32'd0);
    chk({nm, " done"},  32'(done),  32'd0);
    chk({nm, " x"},     32'(vga_x), 32'(ex));
    chk({nm, " y"},     32'(vga_y), 32'(ey));
    chk({nm, " col"},   32'(vga_colour), 32'(ec));
  endtask

  // Reference model: push the full expected output stream for one square.
  task automatic push_square(input vec_t v);
    exp_t e;
    int   sx, sy;
    for (int k = 0; k < NPIX; k++) begin
      sx      = int'(v.x) + (k % SIZE);
      sy      = int'(v.y) + (k / SIZE);
      e.x     = sx[7:0];
      e.y     = sy[6:0];
      e.col   = v.fill ? v.col : 3'b000;
      e.plot  = (sx < SW) && (sy < SH);
      e.done  = 1'b0;
      e.ready = 1'b0;
      sb.push_back(e);
    end
    e.plot  = 1'b0;
    e.done  = 1'b1;
    sb.push_back(e);
    e.done  = 1'b0;
    e.ready = 1'b1;
    sb.push_back(e);
  endtask

  task automatic run_square(input int id, input vec_t v);
    exp_t  e;
    string nm;
    push_square(v);
    @(negedge clk);
    in_x = v.x; in_y = v.y; in_colour = v.col; in_fill = v.fill;
    start = 1'b1;
    for (int c = 1; c <= NPIX + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (v.poke && c == 5) begin
        start = 1'b1;
        in_x  = 8'd100;
      end
      if (v.poke && c == 6) start = 1'b0;
      if (sb.size() == 0) begin
        chk("scoreboard underflow", 32'd1, 32'd0);
      end else begin
        e  = sb.pop_front();
        nm = $sformatf("sq%0d c%0d", id, c);
        chk({nm, " plot"},  32'(plot),  32'(e.plot));
        chk({nm, " done"},  32'(done),  32'(e.done));
        chk({nm, " ready"}, 32'(ready), 32'(e.ready));
        chk({nm, " x"},     32'(vga_x), 32'(e.x));
        chk({nm, " y"},     32'(vga_y), 32'(e.y));
        chk({nm, " col"},   32'(vga_colour), 32'(e.col));
      end
    end
    if (v.poke) begin
      // No queued second square may follow the stray start.
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("sq%0d after c%0d plot", id, c), 32'(plot), 32'd0);
        chk($sformatf("sq%0d after c%0d ready", id, c), 32'(ready), 32'd1);
      end
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{x: 8'd1,   y: 7'd53,  col: 3'b100, fill: 1'b1, poke: 1'b0};
    vecs[1] = '{x: 8'd1,   y: 7'd53,  col: 3'b100, fill: 1'b0, poke: 1'b0};
    vecs[2] = '{x: 8'd158, y: 7'd118, col: 3'b010, fill: 1'b1, poke: 1'b0};
    vecs[3] = '{x: 8'd1,   y: 7'd53,  col: 3'b100, fill: 1'b1, poke: 1'b1};
    vecs[4] = '{x: 8'd0,   y: 7'd0,   col: 3'b011, fill: 1'b1, poke: 1'b0};
    vecs[5] = '{x: 8'd150, y: 7'd117, col: 3'b111, fill: 1'b1, poke: 1'b0};
    vecs[6] = '{x: 8'd254, y: 7'd126, col: 3'b101, fill: 1'b1, poke: 1'b0};

    reset = 1'b1; start = 1'b0; in_x = '0; in_y = '0; in_colour = '0; in_fill = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle($sformatf("reset idle%0d", c), 8'd0, 7'd0, 3'd0);
    end

    for (int i = 0; i < 7; i++) run_square(i, vecs[i]);

    // Reset in the middle of a square: abandoned, no done pulse.
    @(negedge clk);
    in_x = 8'd20; in_y = 7'd30; in_colour = 3'b110; in_fill = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      chk($sformatf("pre-reset c%0d plot", c), 32'(plot), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("mid reset", 8'd0, 7'd0, 3'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("post-reset c%0d done", c), 32'(done), 32'd0);
      chk($sformatf("post-reset c%0d plot", c), 32'(plot), 32'd0);
    end
    v = '{x: 8'd40, y: 7'd10, col: 3'b001, fill: 1'b1, poke: 1'b0};
    run_square(7, v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
